// File: rtl/xif_copro_pkg.sv
// XIF coprocessor writeback: shared types, widths and helpers.
package xif_copro_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int XIF_ID_WIDTH   = 4;
    localparam int XIF_DATA_WIDTH = 32;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0]   id;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XIF_DATA_WIDTH-1:0] data;
        logic                      copro_we;
        logic                      core_we;
    } wb_entry_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xif_copro_writeback_if.sv
// Unit-side, core-side and register-file signals of the writeback stage.
interface xif_copro_writeback_if
    import xif_copro_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int NUM_UNITS  = 2
);

    logic [NUM_UNITS-1:0]                     unit_valid_i;
    logic [NUM_UNITS-1:0]                     unit_ready_o;
    logic [NUM_UNITS-1:0][ID_WIDTH-1:0]       unit_id_i;
    logic [NUM_UNITS-1:0][REG_ADDR_WIDTH-1:0] unit_rd_i;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]     unit_data_i;
    logic [NUM_UNITS-1:0]                     unit_copro_we_i;
    logic [NUM_UNITS-1:0]                     unit_core_we_i;

    logic                      result_valid_o;
    logic                      result_ready_i;
    logic [ID_WIDTH-1:0]       result_id_o;
    logic [REG_ADDR_WIDTH-1:0] result_rd_o;
    logic [DATA_WIDTH-1:0]     result_data_o;
    logic                      result_we_o;

    logic                      rf_we_o;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0]     rf_wdata_o;
    logic                      busy_o;

    modport slave (
        input  unit_valid_i, unit_id_i, unit_rd_i, unit_data_i,
        input  unit_copro_we_i, unit_core_we_i, result_ready_i,
        output unit_ready_o, result_valid_o, result_id_o,
        output result_rd_o, result_data_o, result_we_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, busy_o
    );

    modport master (
        output unit_valid_i, unit_id_i, unit_rd_i, unit_data_i,
        output unit_copro_we_i, unit_core_we_i, result_ready_i,
        input  unit_ready_o, result_valid_o, result_id_o,
        input  result_rd_o, result_data_o, result_we_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, busy_o
    );

endinterface

// File: rtl/xif_copro_wb_fifo.sv
// In-order result buffer; pointers carry a wrap bit to tell full from empty.
module xif_copro_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_i && !full_o) begin
                mem[wr_ptr[AW-1:0]] <= data_i;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                  && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty_o = (wr_ptr == rd_ptr);
    assign head_o  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/xif_copro_writeback.sv
// XIF coprocessor writeback: round-robin collect, in-order buffer,
// one result transaction plus matching register-file write per entry.
module xif_copro_writeback
    import xif_copro_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int NUM_UNITS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic                    clk_i,
    input logic                    rst_i,
    xif_copro_writeback_if.slave   bus
);

    localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]       id;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
        logic                      copro_we;
        logic                      core_we;
    } entry_t;

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        gnt_idx;
    logic [NUM_UNITS-1:0] grant;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    entry_t               push_entry;
    entry_t               head;

    // Scan from the priority pointer; the full flag alone blocks a grant.
    always_comb begin
        int u;
        u       = 0;
        grant   = '0;
        gnt_idx = rr_ptr;
        if (!full) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                u = (int'(rr_ptr) + k) % NUM_UNITS;
                if (bus.unit_valid_i[u] && grant == '0) begin
                    grant[u] = 1'b1;
                    gnt_idx  = PW'(u);
                end
            end
        end
    end

    always_comb begin
        push_entry          = '0;
        push_entry.id       = bus.unit_id_i[gnt_idx];
        push_entry.rd       = bus.unit_rd_i[gnt_idx];
        push_entry.data     = bus.unit_data_i[gnt_idx];
        push_entry.copro_we = bus.unit_copro_we_i[gnt_idx];
        push_entry.core_we  = bus.unit_core_we_i[gnt_idx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= PW'(rr_next(int'(gnt_idx), NUM_UNITS));
        end
    end

    assign push = |grant;
    assign pop  = !empty && bus.result_ready_i;

    xif_copro_wb_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.unit_ready_o   = grant;

    assign bus.result_valid_o = !empty;
    assign bus.result_id_o    = head.id;
    assign bus.result_rd_o    = head.rd;
    assign bus.result_data_o  = head.data;
    assign bus.result_we_o    = head.core_we;

    // The register write rides on the result handshake, never ahead of it.
    assign bus.rf_we_o        = pop && head.copro_we;
    assign bus.rf_waddr_o     = head.rd;
    assign bus.rf_wdata_o     = head.data;

    assign bus.busy_o         = !empty;

endmodule

// File: tb/tb_xif_copro_writeback.sv
// Bench for xif_copro_writeback: vector table, directed latency case,
// randomized traffic against a queue-based reference model.
module tb_xif_copro_writeback;
    import xif_copro_pkg::*;

    localparam int NU    = 2;
    localparam int DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    xif_copro_writeback_if #(
        .DATA_WIDTH (32),
        .ID_WIDTH   (4),
        .NUM_UNITS  (NU)
    ) bus ();

    xif_copro_writeback #(
        .DATA_WIDTH (32),
        .ID_WIDTH   (4),
        .NUM_UNITS  (NU),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [31:0] rf_mem [32];
    always @(posedge clk_i) begin
        if (bus.rf_we_o) rf_mem[bus.rf_waddr_o] <= bus.rf_wdata_o;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] tid(input logic [7:0] t);
        return t[3:0];
    endfunction
    function automatic logic [4:0] trd(input logic [7:0] t);
        return t[7:3];
    endfunction
    function automatic logic [31:0] tdat(input logic [7:0] t);
        return {t, ~t, 8'h5A, t};
    endfunction

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic       rdy;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [1:0] cw;
        logic [1:0] kw;
        logic [1:0] e_gnt;
        logic       e_val;
        logic [7:0] e_tag;
        logic       e_rwe;
        logic       e_rfwe;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic [1:0] v, input logic rdy,
        input logic [7:0] t0, input logic [7:0] t1,
        input logic [1:0] cw, input logic [1:0] kw,
        input logic [1:0] g, input logic val, input logic [7:0] tag,
        input logic rwe, input logic rfwe, input logic busy);
        vec_t x;
        x.rst = r;  x.v = v;  x.rdy = rdy;  x.t0 = t0;  x.t1 = t1;
        x.cw = cw;  x.kw = kw;  x.e_gnt = g;  x.e_val = val;
        x.e_tag = tag;  x.e_rwe = rwe;  x.e_rfwe = rfwe;  x.e_busy = busy;
        return x;
    endfunction

    task automatic drive(input logic r, input logic [1:0] v, input logic rdy,
                         input logic [7:0] t0, input logic [7:0] t1,
                         input logic [1:0] cw, input logic [1:0] kw);
        rst_i                = r;
        bus.unit_valid_i     = v;
        bus.result_ready_i   = rdy;
        bus.unit_id_i        = {tid(t1), tid(t0)};
        bus.unit_rd_i        = {trd(t1), trd(t0)};
        bus.unit_data_i      = {tdat(t1), tdat(t0)};
        bus.unit_copro_we_i  = cw;
        bus.unit_core_we_i   = kw;
    endtask

    wb_entry_t q[$];
    int        ptr;

    initial begin
        drive(1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00);

        // round-robin, both units, draining
        tbl.push_back(mk(0,2'b11,1,8'h10,8'h20,2'b11,2'b01, 2'b01,0,8'h00,0,0,0));
        tbl.push_back(mk(0,2'b11,1,8'h11,8'h21,2'b11,2'b01, 2'b10,1,8'h10,1,1,1));
        tbl.push_back(mk(0,2'b11,1,8'h12,8'h22,2'b11,2'b01, 2'b01,1,8'h21,0,1,1));
        tbl.push_back(mk(0,2'b11,1,8'h13,8'h23,2'b11,2'b01, 2'b10,1,8'h12,1,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b01, 2'b00,1,8'h23,0,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b01, 2'b00,0,8'h00,0,0,0));
        // backpressure until full, then drain (no grant on the full+pop cycle)
        tbl.push_back(mk(0,2'b01,0,8'h30,8'h00,2'b11,2'b00, 2'b01,0,8'h00,0,0,0));
        tbl.push_back(mk(0,2'b01,0,8'h31,8'h00,2'b11,2'b00, 2'b01,1,8'h30,0,0,1));
        tbl.push_back(mk(0,2'b01,0,8'h32,8'h00,2'b11,2'b00, 2'b01,1,8'h30,0,0,1));
        tbl.push_back(mk(0,2'b01,0,8'h33,8'h00,2'b11,2'b00, 2'b01,1,8'h30,0,0,1));
        tbl.push_back(mk(0,2'b01,0,8'h34,8'h00,2'b11,2'b00, 2'b00,1,8'h30,0,0,1));
        tbl.push_back(mk(0,2'b01,0,8'h35,8'h00,2'b11,2'b00, 2'b00,1,8'h30,0,0,1));
        tbl.push_back(mk(0,2'b01,1,8'h36,8'h00,2'b11,2'b00, 2'b00,1,8'h30,0,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,1,8'h31,0,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,1,8'h32,0,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,1,8'h33,0,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,0,8'h00,0,0,0));
        // push and pop together at count 2
        tbl.push_back(mk(0,2'b01,0,8'h40,8'h00,2'b11,2'b00, 2'b01,0,8'h00,0,0,0));
        tbl.push_back(mk(0,2'b10,0,8'h00,8'h41,2'b11,2'b00, 2'b10,1,8'h40,0,0,1));
        tbl.push_back(mk(0,2'b01,1,8'h42,8'h00,2'b11,2'b00, 2'b01,1,8'h40,0,1,1));
        tbl.push_back(mk(0,2'b10,1,8'h00,8'h43,2'b11,2'b00, 2'b10,1,8'h41,0,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,1,8'h42,0,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,1,8'h43,0,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,0,8'h00,0,0,0));
        // core write only
        tbl.push_back(mk(0,2'b10,1,8'h00,8'h50,2'b00,2'b10, 2'b10,0,8'h00,0,0,0));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b00,2'b10, 2'b00,1,8'h50,1,0,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b00,2'b10, 2'b00,0,8'h00,0,0,0));
        // reset with three entries buffered
        tbl.push_back(mk(0,2'b01,0,8'h60,8'h00,2'b11,2'b00, 2'b01,0,8'h00,0,0,0));
        tbl.push_back(mk(0,2'b10,0,8'h00,8'h61,2'b11,2'b00, 2'b10,1,8'h60,0,0,1));
        tbl.push_back(mk(0,2'b01,0,8'h62,8'h00,2'b11,2'b00, 2'b01,1,8'h60,0,0,1));
        tbl.push_back(mk(1,2'b00,0,8'h00,8'h00,2'b11,2'b00, 2'b00,1,8'h60,0,0,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,0,8'h00,0,0,0));
        tbl.push_back(mk(0,2'b11,1,8'h70,8'h71,2'b11,2'b00, 2'b01,0,8'h00,0,0,0));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,1,8'h70,0,1,1));
        tbl.push_back(mk(0,2'b00,1,8'h00,8'h00,2'b11,2'b00, 2'b00,0,8'h00,0,0,0));

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("reset.valid", 32'(bus.result_valid_o), 32'd0);
        chk("reset.rf_we", 32'(bus.rf_we_o), 32'd0);
        chk("reset.busy", 32'(bus.busy_o), 32'd0);
        chk("reset.ready", 32'(bus.unit_ready_o), 32'd0);
        chk("reset.id", 32'(bus.result_id_o), 32'd0);
        chk("reset.data", bus.result_data_o, 32'd0);
        chk("reset.wdata", bus.rf_wdata_o, 32'd0);

        foreach (tbl[i]) begin
            @(negedge clk_i);
            drive(tbl[i].rst, tbl[i].v, tbl[i].rdy, tbl[i].t0, tbl[i].t1,
                  tbl[i].cw, tbl[i].kw);
            #1;
            chk($sformatf("vec%0d.grant", i), 32'(bus.unit_ready_o),
                32'(tbl[i].e_gnt));
            chk($sformatf("vec%0d.valid", i), 32'(bus.result_valid_o),
                32'(tbl[i].e_val));
            chk($sformatf("vec%0d.busy", i), 32'(bus.busy_o),
                32'(tbl[i].e_busy));
            chk($sformatf("vec%0d.rf_we", i), 32'(bus.rf_we_o),
                32'(tbl[i].e_rfwe));
            if (tbl[i].e_val) begin
                chk($sformatf("vec%0d.id", i), 32'(bus.result_id_o),
                    32'(tid(tbl[i].e_tag)));
                chk($sformatf("vec%0d.rd", i), 32'(bus.result_rd_o),
                    32'(trd(tbl[i].e_tag)));
                chk($sformatf("vec%0d.data", i), bus.result_data_o,
                    tdat(tbl[i].e_tag));
                chk($sformatf("vec%0d.result_we", i), 32'(bus.result_we_o),
                    32'(tbl[i].e_rwe));
            end
            if (tbl[i].e_rfwe) begin
                chk($sformatf("vec%0d.waddr", i), 32'(bus.rf_waddr_o),
                    32'(trd(tbl[i].e_tag)));
                chk($sformatf("vec%0d.wdata", i), bus.rf_wdata_o,
                    tdat(tbl[i].e_tag));
            end
            @(posedge clk_i);
        end

        // single result: grant in N, result + rf write in N+1, rf holds in N+2
        @(negedge clk_i);
        rst_i               = 1'b0;
        bus.unit_valid_i    = 2'b01;
        bus.result_ready_i  = 1'b1;
        bus.unit_id_i       = {4'd0, 4'd3};
        bus.unit_rd_i       = {5'd0, 5'd7};
        bus.unit_data_i     = {32'd0, 32'hDEADBEEF};
        bus.unit_copro_we_i = 2'b01;
        bus.unit_core_we_i  = 2'b00;
        #1;
        chk("single.grant", 32'(bus.unit_ready_o), 32'd1);
        chk("single.valid_n", 32'(bus.result_valid_o), 32'd0);
        @(negedge clk_i);
        bus.unit_valid_i = 2'b00;
        #1;
        chk("single.valid_n1", 32'(bus.result_valid_o), 32'd1);
        chk("single.id", 32'(bus.result_id_o), 32'd3);
        chk("single.result_we", 32'(bus.result_we_o), 32'd0);
        chk("single.rf_we", 32'(bus.rf_we_o), 32'd1);
        chk("single.waddr", 32'(bus.rf_waddr_o), 32'd7);
        chk("single.wdata", bus.rf_wdata_o, 32'hDEADBEEF);
        @(negedge clk_i);
        #1;
        chk("single.rf_hold", rf_mem[7], 32'hDEADBEEF);
        chk("single.valid_n2", 32'(bus.result_valid_o), 32'd0);

        // randomized traffic against the reference queue
        @(negedge clk_i);
        drive(1'b1, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 2'b00);
        @(posedge clk_i);
        q.delete();
        ptr = 0;
        for (int c = 0; c < 800; c++) begin
            logic       r;
            logic [1:0] v;
            logic       rdy;
            logic [1:0] eg;
            logic       ev;
            logic       erf;
            int         gi;
            wb_entry_t  u [NU];
            @(negedge clk_i);
            r   = ($urandom_range(0, 79) == 0);
            v   = 2'($urandom);
            rdy = (((c / 32) % 2) == 0) ? ($urandom_range(0, 7) != 0)
                                         : ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NU; k++) begin
                u[k].id       = 4'($urandom);
                u[k].rd       = 5'($urandom);
                u[k].data     = $urandom;
                u[k].copro_we = 1'($urandom);
                u[k].core_we  = 1'($urandom);
            end
            rst_i               = r;
            bus.unit_valid_i    = v;
            bus.result_ready_i  = rdy;
            bus.unit_id_i       = {u[1].id, u[0].id};
            bus.unit_rd_i       = {u[1].rd, u[0].rd};
            bus.unit_data_i     = {u[1].data, u[0].data};
            bus.unit_copro_we_i = {u[1].copro_we, u[0].copro_we};
            bus.unit_core_we_i  = {u[1].core_we, u[0].core_we};
            #1;
            eg = '0;
            gi = -1;
            if (q.size() < DEPTH) begin
                for (int k = 0; k < NU; k++) begin
                    int x;
                    x = (ptr + k) % NU;
                    if (gi < 0 && v[x]) begin
                        gi    = x;
                        eg[x] = 1'b1;
                    end
                end
            end
            ev  = (q.size() != 0);
            erf = ev && rdy && q[0].copro_we;
            chk($sformatf("rnd%0d.grant", c), 32'(bus.unit_ready_o), 32'(eg));
            chk($sformatf("rnd%0d.valid", c), 32'(bus.result_valid_o), 32'(ev));
            chk($sformatf("rnd%0d.busy", c), 32'(bus.busy_o), 32'(ev));
            chk($sformatf("rnd%0d.rf_we", c), 32'(bus.rf_we_o), 32'(erf));
            if (ev) begin
                chk($sformatf("rnd%0d.id", c), 32'(bus.result_id_o),
                    32'(q[0].id));
                chk($sformatf("rnd%0d.rd", c), 32'(bus.result_rd_o),
                    32'(q[0].rd));
                chk($sformatf("rnd%0d.data", c), bus.result_data_o, q[0].data);
                chk($sformatf("rnd%0d.result_we", c), 32'(bus.result_we_o),
                    32'(q[0].core_we));
            end
            if (erf) begin
                chk($sformatf("rnd%0d.waddr", c), 32'(bus.rf_waddr_o),
                    32'(q[0].rd));
                chk($sformatf("rnd%0d.wdata", c), bus.rf_wdata_o, q[0].data);
            end
            @(posedge clk_i);
            if (r) begin
                q.delete();
                ptr = 0;
            end else begin
                if (ev && rdy) void'(q.pop_front());
                if (gi >= 0) begin
                    q.push_back(u[gi]);
                    ptr = (gi + 1) % NU;
                end
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/xif_copro_writeback.md
# xif_copro_writeback

Writeback stage of the XIF coprocessor: collects completed results from the coprocessor execution units, orders them through a small in-order buffer, and drains each entry as one XIF result transaction to the core. In the same cycle as that transaction, it performs the matching write into the coprocessor register file. It is the single writer of the register file write port and the single driver of the core-facing result channel.

## Interface
Parameters:
- DATA_WIDTH, 32, result/register data width
- ID_WIDTH, 4, XIF instruction id width
- NUM_UNITS, 2, number of execution units feeding writeback (≥1)
- FIFO_DEPTH, 4, result buffer entries (power of two, ≥2)

Ports:
- clk_i  in  1  clock; everything samples on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- unit_valid_i  in  [NUM_UNITS]  unit offers a result
- unit_ready_o  out  [NUM_UNITS]  result accepted this cycle (grant)
- unit_id_i  in  [NUM_UNITS][ID_WIDTH]  instruction id
- unit_rd_i  in  [NUM_UNITS][5]  destination register index
- unit_data_i  in  [NUM_UNITS][DATA_WIDTH]  result data
- unit_copro_we_i  in  [NUM_UNITS]  write coprocessor register file
- unit_core_we_i  in  [NUM_UNITS]  core integer register writeback requested
- result_valid_o  out  1  XIF result valid
- result_ready_i  in  1  core accepts result
- result_id_o  out  ID_WIDTH  result id
- result_rd_o  out  5  result destination index
- result_data_o  out  DATA_WIDTH  result data
- result_we_o  out  1  core must write rd
- rf_we_o  out  1  register file write enable (one port)
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DATA_WIDTH  register file write data
- busy_o  out  1  buffer non-empty

## Operation
- Arbitration: round-robin over units with unit_valid_i high; at most one grant per cycle, and only when the buffer is not full. The priority pointer starts at unit 0 and, after each grant, moves to the unit following the granted one. unit_ready_o depends on valid inputs, the pointer and the full flag only; it never depends on result_ready_i.
- Granted entry {id, rd, data, copro_we, core_we} is pushed at the clock edge.
- Buffer: in-order FIFO with read/write pointers carrying an extra wrap bit. Full = indices equal and wrap bits differ; empty = pointers equal. Pointers wrap modulo FIFO_DEPTH.
- Drain: result_valid_o = !empty; the result_* outputs show the head entry. The head pops on result_valid_o && result_ready_i.
- Every entry produces exactly one result transaction, including entries with core_we=0 (result_we_o=0).
- Register file write: rf_we_o = result_valid_o && result_ready_i && head.copro_we; rf_waddr_o/rf_wdata_o = head rd/data. Exactly one write per entry, in buffer order. No write occurs without a completed result handshake.
- Push and pop in the same cycle: both take effect and the count is unchanged. When full, no grant is given, even if a pop happens that cycle.
- result_valid_o is held and the head is stable until the handshake completes.
- Reset: pointers zero, round-robin pointer at unit 0, buffer empty. Reset discards any buffered entries without writing them.

## Timing
- Reset values: result_valid_o=0, rf_we_o=0, busy_o=0, unit_ready_o=0; result_*/rf_* data outputs are 0 (empty buffer memory cleared).
- Latency: a grant in cycle N makes result_valid_o high in cycle N+1 (buffer previously empty). With result_ready_i high in N+1, rf_we_o pulses in N+1 and the register file holds the new value from N+2.
- Throughput: one entry per cycle sustained while result_ready_i stays high.
- No combinational path from any unit input to any result_*/rf_* output.

## Structure
- xif_copro_pkg: wb_entry_t struct {id, rd, data, copro_we, core_we}, REG_ADDR_WIDTH=5.
- One sub-module, xif_copro_wb_fifo: parameterised synchronous FIFO with push/pop/full/empty and head output. Arbitration and drain logic sit in the top module.

## Test plan
- Single result: unit0 {id=3, rd=7, data=0xDEADBEEF, copro_we=1, core_we=0}, result_ready_i=1 → result_valid_o high one cycle later with id=3 and result_we_o=0; rf_we_o pulses with waddr=7 and wdata=0xDEADBEEF.
- Round-robin: both units valid for 4 cycles, buffer draining → grants alternate 0,1,0,1, and results emerge in the same order.
- Full/backpressure: result_ready_i=0 with 6 offers and FIFO_DEPTH=4 → 4 accepted, unit_ready_o low afterwards, busy_o=1, no rf_we_o. Raising ready → 4 results in order, one rf write each.
- Simultaneous push/pop at count 2 → count stays 2 and order is preserved.
- core_we=1, copro_we=0 entry → result_we_o=1 and rf_we_o stays 0.
- rst_i asserted with 3 entries buffered → next cycle result_valid_o=0 and busy_o=0, with no rf write.
